pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_buffer.sv | 90 +++++++++
 rtl/pc_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, the default
// reset PC, the fetch FSM state encoding and the instruction buffer entry.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

    // IDLE: nothing outstanding, WAIT: one request in flight, HALT: fault stop
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits so a redirect target always lands on a word
    function automatic logic [ADDR_W-1:0] alignWord(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding fetched {pc, inst} pairs between instruction memory and
// decode. Simultaneous push and pop both take effect, even when full, and a
// flush empties the FIFO regardless of any push in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] wrPtr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             isEmpty;
    logic             isFull;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CNT_W'(DEPTH));
    assign doPop   = pop && !isEmpty;
    assign doPush  = push && (!isFull || doPop);

    // Next pointer/count values; a flush resets everything to empty
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_d = count_q + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as valid
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            mem_q[wrPtr_q] <= push_entry;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rdPtr_q];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues one instruction-memory
// request at a time, buffers returned words for decode and handles redirects
// from the next-PC selector, discarding any response made stale by them.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target raises a sticky misalign_fault and halts fetch
// until reset; when undefined, redirect targets are silently word-aligned.
// BUF_DEPTH is meant to be 2..4.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign_fault
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic              discard_q;
    logic [ADDR_W-1:0] redirectTarget;
    logic              ackAccept;
    logic              pushEn;
    logic              popEn;
    logic              canIssue;
    logic [CNT_W-1:0]  bufCount;
    fetch_entry_t      pushEntry;
    fetch_entry_t      headEntry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic              fault_q;
    logic              misaligned;

    assign misaligned     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirectTarget = redirect_pc;
    assign misalign_fault = fault_q;
`else
    assign redirectTarget = alignWord(redirect_pc);
`endif

    // Acks only count while a request is outstanding; anything else is noise
    assign ackAccept = (state_q == WAIT) && imem_ack;
    // A redirect or a discard flag makes the returning word stale
    assign pushEn    = ackAccept && !discard_q && !redirect_valid;
    assign popEn     = inst_valid && inst_ready;
    // Never issue on a redirect cycle so the request always uses the final target
    assign canIssue  = (state_q == IDLE) && !redirect_valid
                       && (bufCount < CNT_W'(BUF_DEPTH));

    assign pushEntry.pc   = addr_q;
    assign pushEntry.inst = imem_rdata;

    // Next fetch PC: a redirect wins over sequential advance on a good ack
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirectTarget;
        end else if (pushEn) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Fetch FSM with registered request, address, discard flag and fault
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    if (canIssue) begin
                        state_q <= WAIT;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                WAIT: begin
                    if (ackAccept) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        discard_q <= 1'b0;
                    end else if (redirect_valid) begin
                        discard_q <= 1'b1;
                    end
                end
                HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
                state_q   <= HALT;
                req_q     <= 1'b0;
                discard_q <= 1'b0;
                fault_q   <= 1'b1;
            end
`endif
        end
    end

    fetch_buffer #(
        .DEPTH      (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pushEn),
        .push_entry (pushEntry),
        .pop        (popEn),
        .flush      (redirect_valid),
        .count      (bufCount),
        .head       (headEntry)
    );

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign pc_plus4   = pc_q + PC_STEP;
    assign inst_valid = (bufCount != '0);
    assign inst_data  = headEntry.inst;
    assign inst_pc    = headEntry.pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit (RESET_PC = 0, BUF_DEPTH = 2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] pcPlus4;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instValid;
    logic        instReady;
    logic [31:0] instData;
    logic [31:0] instPc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalignFault;
`endif

    int compCount = 0;
    int errCount  = 0;

    pc_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .BUF_DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .pc_plus4       (pcPlus4),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_ack       (imemAck),
        .imem_rdata     (imemRdata),
        .inst_valid     (instValid),
        .inst_ready     (instReady),
        .inst_data      (instData),
        .inst_pc        (instPc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault (misalignFault)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory word returned for a given address
    function automatic logic [31:0] dataFor(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Drive one cycle of inputs, then sample just after the next rising edge
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic ready, input logic rv,
                                 input logic [31:0] rpc);
        imemAck       = ack;
        imemRdata     = rdata;
        instReady     = ready;
        redirectValid = rv;
        redirectPc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        rstN = 1'b1;
    endtask

    initial begin
        rstN          = 1'b0;
        imemAck       = 1'b0;
        imemRdata     = 32'h0;
        instReady     = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;

        // ---- Reset state
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req", imemReq, 1'b0);
        checkOutput("rst_valid", instValid, 1'b0);
        checkOutput("rst_pc_plus4", pcPlus4, 32'h4);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("rst_fault", misalignFault, 1'b0);
`endif

        // ---- First request straight out of reset at RESET_PC
        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("first_req", imemReq, 1'b1);
        checkOutput("first_addr", imemAddr, 32'h0);

        // ---- Streaming with inst_ready high: 0x0, 0x4, 0x8 one per 2 cycles
        applyStimulus(1'b1, dataFor(32'h0), 1'b1, 1'b0, 32'h0);
        checkOutput("s0_req_drop", imemReq, 1'b0);
        checkOutput("s0_valid", instValid, 1'b1);
        checkOutput("s0_inst_pc", instPc, 32'h0);
        checkOutput("s0_inst_data", instData, dataFor(32'h0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("s1_req", imemReq, 1'b1);
        checkOutput("s1_addr", imemAddr, 32'h4);
        checkOutput("s1_valid_popped", instValid, 1'b0);
        applyStimulus(1'b1, dataFor(32'h4), 1'b1, 1'b0, 32'h0);
        checkOutput("s1_inst_pc", instPc, 32'h4);
        checkOutput("s1_inst_data", instData, dataFor(32'h4));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("s2_addr", imemAddr, 32'h8);
        applyStimulus(1'b1, dataFor(32'h8), 1'b1, 1'b0, 32'h0);
        checkOutput("s2_inst_pc", instPc, 32'h8);
        checkOutput("s2_pc_plus4", pcPlus4, 32'h10);

        // ---- Stall with inst_ready low: exactly two fetches then no request
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("st_addr0", imemAddr, 32'h0);
        applyStimulus(1'b1, dataFor(32'h0), 1'b0, 1'b0, 32'h0);
        checkOutput("st_head0", instPc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("st_req1", imemReq, 1'b1);
        checkOutput("st_addr1", imemAddr, 32'h4);
        applyStimulus(1'b1, dataFor(32'h4), 1'b0, 1'b0, 32'h0);
        checkOutput("st_full_req", imemReq, 1'b0);
        checkOutput("st_head_hold", instPc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("st_no_req", imemReq, 1'b0);
        checkOutput("st_head_data", instData, dataFor(32'h0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("st_drain_pc4", instPc, 32'h4);
        checkOutput("st_drain_noreq", imemReq, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("st_resume_req", imemReq, 1'b1);
        checkOutput("st_resume_addr", imemAddr, 32'h8);
        checkOutput("st_empty", instValid, 1'b0);

        // ---- Redirect to 0x100 while 0x8 is outstanding; ack arrives late
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
        checkOutput("rd_req_held", imemReq, 1'b1);
        checkOutput("rd_addr_held", imemAddr, 32'h8);
        checkOutput("rd_flushed", instValid, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_addr_stable", imemAddr, 32'h8);
        applyStimulus(1'b1, dataFor(32'h8), 1'b1, 1'b0, 32'h0);
        checkOutput("rd_dropped", instValid, 1'b0);
        checkOutput("rd_ack_req", imemReq, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_new_req", imemReq, 1'b1);
        checkOutput("rd_new_addr", imemAddr, 32'h100);
        checkOutput("rd_never_valid", instValid, 1'b0);

        // ---- Back-to-back redirects in IDLE: the last one wins
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        checkOutput("bb_no_req", imemReq, 1'b0);
        checkOutput("bb_pc_plus4_a", pcPlus4, 32'h44);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10);
        checkOutput("bb_pc_plus4_b", pcPlus4, 32'h14);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("bb_addr", imemAddr, 32'h10);

        // ---- Redirect to 0x200 in the same cycle as the 0x10 ack
        applyStimulus(1'b1, dataFor(32'h10), 1'b1, 1'b1, 32'h200);
        checkOutput("ra_empty", instValid, 1'b0);
        checkOutput("ra_req", imemReq, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("ra_new_req", imemReq, 1'b1);
        checkOutput("ra_new_addr", imemAddr, 32'h200);

        // ---- PC wrap at the top of the address space
        applyStimulus(1'b1, dataFor(32'h200), 1'b1, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wr_pc_plus4_top", pcPlus4, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("wr_addr_top", imemAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, dataFor(32'hFFFF_FFFC), 1'b1, 1'b0, 32'h0);
        checkOutput("wr_inst_pc", instPc, 32'hFFFF_FFFC);
        checkOutput("wr_pc_plus4", pcPlus4, 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("wr_req", imemReq, 1'b1);
        checkOutput("wr_addr_zero", imemAddr, 32'h0);

        // ---- Misaligned redirect target 0x102 while 0x0 is outstanding
`ifdef FETCH_MISALIGN_CHECK_EN
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h102);
        checkOutput("ma_fault", misalignFault, 1'b1);
        checkOutput("ma_req", imemReq, 1'b0);
        checkOutput("ma_flushed", instValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, dataFor(32'h0), 1'b1, 1'b0, 32'h0);
            checkOutput("ma_halt_req", imemReq, 1'b0);
            checkOutput("ma_fault_sticky", misalignFault, 1'b1);
        end
`else
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h102);
        checkOutput("al_pc_plus4", pcPlus4, 32'h104);
        applyStimulus(1'b1, dataFor(32'h0), 1'b1, 1'b0, 32'h0);
        checkOutput("al_dropped", instValid, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("al_addr", imemAddr, 32'h100);
`endif

        // ---- Reset mid-request, then a stray ack while IDLE is ignored
        rstN = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("mr_rst_req", imemReq, 1'b0);
        checkOutput("mr_rst_valid", instValid, 1'b0);
        rstN = 1'b1;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        checkOutput("mr_req", imemReq, 1'b1);
        checkOutput("mr_addr", imemAddr, 32'h0);
        checkOutput("mr_stray_ignored", instValid, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("mr_fault_cleared", misalignFault, 1'b0);
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("mr_req_held", imemReq, 1'b1);
        checkOutput("mr_still_empty", instValid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
